ddr3_app_initiator: RTL
=======================

DDR3_APP_INITIATOR -- requirements
Module: ddr3_app_initiator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, meaning the MIG app_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, meaning the app_wdf_data/app_rd_data width (nCK_PER_CLK=4 x 2 x 64).
REQ-003 SHALL have parameter RD_DEPTH, default 8, meaning the read-return buffer depth; power of two, 2..64.
REQ-004 SHALL have ports ui_clk in 1 (sole clock) and ui_clk_sync_rst in 1 (synchronous, active-high reset).
REQ-005 SHALL have ports req_valid in 1, req_rdy out 1, req_write in 1, req_addr in ADDR_WIDTH, req_data in DATA_WIDTH, req_mask in DATA_WIDTH/8 (1 = byte not written).
REQ-006 SHALL have ports resp_valid out 1, resp_rdy in 1, resp_data out DATA_WIDTH.
REQ-007 SHALL have MIG-side ports app_addr out ADDR_WIDTH, app_cmd out 3, app_en out 1, app_rdy in 1, app_wdf_data out DATA_WIDTH, app_wdf_mask out DATA_WIDTH/8, app_wdf_wren out 1, app_wdf_end out 1, app_wdf_rdy in 1, app_rd_data in DATA_WIDTH, app_rd_data_valid in 1, init_calib_complete in 1.
REQ-008 SHALL have ports err_overflow out 1 (sticky), stat_rd_count out 32, stat_wr_count out 32.

Function
REQ-009 SHALL implement FSM states IDLE and BUSY; IDLE->BUSY on req_valid&&req_rdy; BUSY->IDLE in the cycle the last outstanding handshake (command, plus write data for writes) completes.
REQ-010 SHALL drive req_rdy = (state==IDLE) && init_calib_complete && (outstanding < RD_DEPTH), with no combinational dependence on req_valid or req_write.
REQ-011 SHALL register address, command, data and mask on acceptance; app_en, app_wdf_wren rise exactly one cycle after acceptance.
REQ-012 SHALL encode app_cmd 3'b000 for write and 3'b001 for read.
REQ-013 SHALL hold app_en and app_addr/app_cmd stable until a cycle with app_en&&app_rdy, then deassert app_en the next cycle.
REQ-014 SHALL, for writes only, hold app_wdf_wren and app_wdf_data/app_wdf_mask stable until a cycle with app_wdf_wren&&app_wdf_rdy, then deassert; app_wdf_end SHALL equal app_wdf_wren (single-beat).
REQ-015 SHALL track command and write-data completion independently; either may finish first, and both SHALL finish before returning to IDLE.
REQ-016 SHALL keep outstanding counter (width log2(RD_DEPTH)+1): +1 on read command accept (app_en&&app_rdy, read), -1 on resp_valid&&resp_rdy; simultaneous events leave it unchanged.
REQ-017 SHALL push app_rd_data into a RD_DEPTH FIFO on every app_rd_data_valid; resp_valid SHALL assert the cycle after the push into an empty FIFO; data returns in MIG order.
REQ-018 SHALL never backpressure app_rd_data_valid; push while FIFO full SHALL drop the beat and set err_overflow until reset.
REQ-019 SHALL support simultaneous FIFO push and pop when full (pop frees the slot, push accepted, no overflow).
REQ-020 SHALL hold resp_data stable while resp_valid&&!resp_rdy.
REQ-021 SHALL accept no request while init_calib_complete is low; deassertion mid-BUSY SHALL NOT abort the in-progress handshakes.

Reset
REQ-022 SHALL, on ui_clk_sync_rst, set state IDLE, req_rdy 0, app_en 0, app_wdf_wren 0, app_wdf_end 0, app_cmd 0, app_addr 0, resp_valid 0, outstanding 0, FIFO empty, err_overflow 0, stat counters 0.
REQ-023 SHALL, on reset mid-operation, abandon the in-flight request and discard buffered read data, without emitting a response.

Configuration
REQ-024 SHALL, when DDR3_APP_INITIATOR_STATS_EN is defined, increment stat_rd_count/stat_wr_count (wrapping at 2^32) per read/write command accepted by app_rdy.
REQ-025 SHALL, when DDR3_APP_INITIATOR_STATS_EN is undefined, tie stat_rd_count and stat_wr_count to 0 with no counter logic.

Verification
REQ-026 Write addr 0x100, data pattern A5.., mask 0, app_rdy/app_wdf_rdy high -> app_en and app_wdf_wren high one cycle each, app_cmd 000, req_rdy back high 2 cycles after accept.
REQ-027 Write with app_rdy low 3 cycles, app_wdf_rdy high -> wdf completes first, app_en held 4 cycles with stable addr, IDLE after command accept.
REQ-028 Read addr 0x200, app_rd_data_valid 10 cycles later with 0xDEAD.. -> resp_valid next cycle, resp_data 0xDEAD.., outstanding returns 0 on pop.
REQ-029 RD_DEPTH=8, resp_rdy low, issue 9 reads -> 8 accepted, req_rdy low; one pop -> 9th accepted; err_overflow stays 0.
REQ-030 Force app_rd_data_valid with FIFO full -> err_overflow 1 and sticky; reset mid-BUSY -> all outputs at reset values next cycle.
REQ-031 With DDR3_APP_INITIATOR_STATS_EN, 5 writes + 3 reads -> stat_wr_count 5, stat_rd_count 3; without macro -> both 0.

Source files
------------

// File: rtl/ddr3_app_initiator.sv
// ddr3_app_initiator: single-request bridge onto the MIG user (app_*) interface.
// One read or write is issued at a time; read data returns through a small FIFO.
// Optional build macro DDR3_APP_INITIATOR_STATS_EN enables the command counters,
// otherwise stat_rd_count/stat_wr_count are tied to zero.
module ddr3_app_initiator #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 512,
  parameter int RD_DEPTH   = 8
) (
  input  logic                    ui_clk,
  input  logic                    ui_clk_sync_rst,
  input  logic                    req_valid,
  output logic                    req_rdy,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [DATA_WIDTH/8-1:0] req_mask,
  output logic                    resp_valid,
  input  logic                    resp_rdy,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]              app_cmd,
  output logic                    app_en,
  input  logic                    app_rdy,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_wren,
  output logic                    app_wdf_end,
  input  logic                    app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   app_rd_data,
  input  logic                    app_rd_data_valid,
  input  logic                    init_calib_complete,
  output logic                    err_overflow,
  output logic [31:0]             stat_rd_count,
  output logic [31:0]             stat_wr_count
);

  localparam int PTR_W = $clog2(RD_DEPTH);
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [PTR_W:0]   DEPTH_VAL = (PTR_W+1)'(RD_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic [PTR_W:0] outstanding;
  logic [DATA_WIDTH-1:0] fifo_mem [RD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0] fifo_count;
  logic accept;
  logic cmd_fire;
  logic wdf_fire;
  logic rd_cmd_fire;
  logic fifo_full;
  logic push;
  logic pop;

  // Reads are only admitted while the return FIFO is guaranteed room for their data.
  assign req_rdy     = (state == IDLE) && init_calib_complete && (outstanding < DEPTH_VAL)
                       && !ui_clk_sync_rst;
  assign accept      = req_valid && req_rdy;
  assign cmd_fire    = app_en && app_rdy;
  assign wdf_fire    = app_wdf_wren && app_wdf_rdy;
  assign rd_cmd_fire = cmd_fire && (app_cmd == CMD_READ);
  assign app_wdf_end = app_wdf_wren;

  assign fifo_full  = (fifo_count == DEPTH_VAL);
  assign resp_valid = (fifo_count != '0);
  assign resp_data  = fifo_mem[rd_ptr];
  assign pop        = resp_valid && resp_rdy;
  assign push       = app_rd_data_valid && (!fifo_full || pop);

  // Request FSM: latch the request, then retire command and write-data handshakes independently.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state        <= IDLE;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= CMD_WRITE;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            app_addr     <= req_addr;
            app_cmd      <= req_write ? CMD_WRITE : CMD_READ;
            app_wdf_data <= req_data;
            app_wdf_mask <= req_mask;
            app_en       <= 1'b1;
            app_wdf_wren <= req_write;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cmd_fire) app_en <= 1'b0;
          if (wdf_fire) app_wdf_wren <= 1'b0;
          if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads in flight or buffered but not yet consumed by the requester.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_cmd_fire, pop})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Return-data storage; contents need no reset because the count gates visibility.
  always_ff @(posedge ui_clk) begin
    if (push) fifo_mem[wr_ptr] <= app_rd_data;
  end

  // FIFO pointers and occupancy; a beat arriving with no free slot is dropped and flagged.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (app_rd_data_valid && !push) err_overflow <= 1'b1;
    end
  end

`ifdef DDR3_APP_INITIATOR_STATS_EN
  // Count commands as the MIG accepts them, wrapping naturally at 2^32.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      stat_rd_count <= '0;
      stat_wr_count <= '0;
    end else if (cmd_fire) begin
      if (app_cmd == CMD_READ) stat_rd_count <= stat_rd_count + 32'd1;
      else                     stat_wr_count <= stat_wr_count + 32'd1;
    end
  end
`else
  assign stat_rd_count = 32'd0;
  assign stat_wr_count = 32'd0;
`endif

endmodule
